// File: rtl/mips_fetch_module.sv
// MIPS IF stage: program counter plus a direct-mapped, read-only instruction
// cache filled one 128-bit line per miss cycle. The cache is invalidated only by reset.
module mips_fetch_module #(
   parameter int LINES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  pc_branch,
   input  logic [127:0] mem_in,
   input  logic         PCSrc,
   output logic [31:0]  instruction,
   output logic         hit,
   output logic [31:0]  add_out
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;

   // Address field helpers; PC[1:0] never reach the cache.
   function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
      return pc[4 +: IDX_W];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
      return pc[4 + IDX_W +: TAG_W];
   endfunction

   function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
      logic [31:0] w;
      case (sel)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         2'd3:    w = line[127:96];
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   logic [31:0]      pc_r;
   logic [127:0]     data_r  [LINES];
   logic [TAG_W-1:0] tag_r   [LINES];
   logic [LINES-1:0] valid_r;

   logic [IDX_W-1:0] idx_s;
   logic [TAG_W-1:0] tag_s;
   logic             hit_s;
   logic [31:0]      word_s;
   logic [31:0]      pc_plus4_s;
   logic [31:0]      pc_next_s;
   logic             fill_s;

   // Cache lookup from the current PC.
   always_comb begin
      idx_s      = pc_index(pc_r);
      tag_s      = pc_tag(pc_r);
      hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
      word_s     = line_word(data_r[idx_s], pc_r[3:2]);
      pc_plus4_s = pc_r + 32'd4;
   end

   // Next PC and fill decision: a branch pre-empts a fill, a hit advances, a miss stalls one cycle.
   always_comb begin
      pc_next_s = pc_r;
      fill_s    = 1'b0;
      if (PCSrc) begin
         pc_next_s = pc_branch;
         fill_s    = 1'b0;
      end else if (hit_s) begin
         pc_next_s = pc_plus4_s;
         fill_s    = 1'b0;
      end else begin
         pc_next_s = pc_r;
         fill_s    = 1'b1;
      end
   end

   // Output drive to the IF/ID boundary; a miss presents a NOP.
   always_comb begin
      hit     = hit_s;
      add_out = pc_plus4_s;
      if (hit_s) begin
         instruction = word_s;
      end else begin
         instruction = 32'h0000_0000;
      end
   end

   // Program counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= 32'h0000_0000;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // Valid bits: cleared by reset, set when a line is filled.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else if (fill_s) begin
         valid_r[idx_s] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Line data and tag storage; no reset needed since valid gates every use.
   always_ff @(posedge clk) begin
      if (!rst && fill_s) begin
         data_r[idx_s] <= mem_in;
         tag_r[idx_s]  <= tag_s;
      end
   end

endmodule

// File: tb/tb_mips_fetch_module.sv
// Directed bench for mips_fetch_module: fills, sequential hits, branches, conflicts, wrap and reset.
module tb_mips_fetch_module;

   logic         clk;
   logic         rst;
   logic [31:0]  pc_branch;
   logic [127:0] mem_in;
   logic         PCSrc;
   logic [31:0]  instruction;
   logic         hit;
   logic [31:0]  add_out;

   int tests_run;
   int tests_failed;

   localparam logic [127:0] MEM_A = {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_7C00};
   localparam logic [127:0] MEM_B = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

   mips_fetch_module #(.LINES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_branch   (pc_branch),
      .mem_in      (mem_in),
      .PCSrc       (PCSrc),
      .instruction (instruction),
      .hit         (hit),
      .add_out     (add_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (got !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input logic h, input logic [31:0] ins, input logic [31:0] add);
      check_value({name, ".hit"}, {31'd0, hit}, {31'd0, h});
      check_value({name, ".instr"}, instruction, ins);
      check_value({name, ".add_out"}, add_out, add);
   endtask

   task automatic branch_to(input logic [31:0] target);
      PCSrc     = 1'b1;
      pc_branch = target;
      step();
      PCSrc     = 1'b0;
      pc_branch = 32'd0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      PCSrc     = 1'b0;
      pc_branch = 32'd0;
      mem_in    = MEM_A;
      step();
      step();
      expect_state("reset", 1'b0, 32'h0, 32'd4);
      rst = 1'b0;
      #1;
      expect_state("cold_miss", 1'b0, 32'h0, 32'd4);

      step();
      expect_state("fill0", 1'b1, 32'h0000_7C00, 32'd4);
      step();
      expect_state("seq4", 1'b1, 32'hFFFF_FFFF, 32'd8);
      step();
      expect_state("seq8", 1'b1, 32'h0000_0000, 32'd12);
      step();
      expect_state("seq12", 1'b1, 32'hFFFF_FFFF, 32'd16);
      step();
      expect_state("miss16", 1'b0, 32'h0, 32'd20);
      step();
      expect_state("fill16", 1'b1, 32'h0000_7C00, 32'd20);

      // Branch while hitting.
      branch_to(32'd8);
      expect_state("br8", 1'b1, 32'h0000_0000, 32'd12);

      // Branch during a miss cancels the fill of line 2.
      branch_to(32'h20);
      expect_state("miss20", 1'b0, 32'h0, 32'h24);
      mem_in = MEM_B;
      branch_to(32'h30);
      expect_state("br_in_miss", 1'b0, 32'h0, 32'h34);
      branch_to(32'h20);
      expect_state("no_fill20", 1'b0, 32'h0, 32'h24);
      step();
      expect_state("fill20", 1'b1, 32'h4444_4444, 32'h24);

      // Conflict at index 0 with a different tag.
      branch_to(32'h100);
      expect_state("conf_miss", 1'b0, 32'h0, 32'h104);
      step();
      expect_state("conf_fill", 1'b1, 32'h4444_4444, 32'h104);
      mem_in = MEM_A;
      branch_to(32'h0);
      expect_state("evicted0", 1'b0, 32'h0, 32'd4);
      step();
      expect_state("refill0", 1'b1, 32'h0000_7C00, 32'd4);

      // Low PC bits ignored.
      branch_to(32'h0000_0007);
      expect_state("low_bits", 1'b1, 32'hFFFF_FFFF, 32'h0000_000B);

      // Wrap at the top of the address space.
      mem_in = MEM_B;
      branch_to(32'hFFFF_FFFC);
      expect_state("wrap_miss", 1'b0, 32'h0, 32'h0);
      step();
      expect_state("wrap_fill", 1'b1, 32'h1111_1111, 32'h0);
      step();
      expect_state("wrap_to0", 1'b1, 32'h0000_7C00, 32'd4);

      // Reset during a miss: nothing written, all lines invalid.
      branch_to(32'h40);
      expect_state("miss40", 1'b0, 32'h0, 32'h44);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      expect_state("rst_mid", 1'b0, 32'h0, 32'd4);
      branch_to(32'h40);
      expect_state("rst_nofill40", 1'b0, 32'h0, 32'h44);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
